// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : Shared types and encodings for the load/store unit.
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    // Controller states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } lsu_state_t;

    // Access size encodings carried on req_size
    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;
    localparam logic [1:0] SIZE_RSVD = 2'd3;

    // Width of one byte lane in the data word
    localparam int LANE_WIDTH = 8;

endpackage
`default_nettype wire

// File: rtl/byte_lane_align.sv
`default_nettype none
// ============================================================================
// Module      : byte_lane_align
// Description : Little-endian byte-lane extraction (loads) and lane merge
//               (read-modify-write stores) for a 32-bit memory word.
// Revision    : 1.0 - initial release
// ============================================================================
module byte_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        is_signed,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [31:0] merged
);

    logic [4:0]  w_shift;
    logic [31:0] w_shifted;
    logic [31:0] w_mask;

    // Offset k selects bits [8k+7:8k]
    assign w_shift   = {offset, 3'b000};
    assign w_shifted = word >> w_shift;

    // Right-justify the addressed lane(s) and sign- or zero-extend
    always_comb begin
        rdata = word;
        case (size)
            SIZE_BYTE: rdata = {{(32-LANE_WIDTH){is_signed & w_shifted[LANE_WIDTH-1]}},
                                w_shifted[LANE_WIDTH-1:0]};
            SIZE_HALF: rdata = {{(32-2*LANE_WIDTH){is_signed & w_shifted[2*LANE_WIDTH-1]}},
                                w_shifted[2*LANE_WIDTH-1:0]};
            default:   rdata = word;
        endcase
    end

    // Replace only the addressed lane(s); full words pass the store data through
    always_comb begin
        w_mask = 32'hFFFF_FFFF;
        case (size)
            SIZE_BYTE: w_mask = 32'h0000_00FF << w_shift;
            SIZE_HALF: w_mask = 32'h0000_FFFF << w_shift;
            default:   w_mask = 32'hFFFF_FFFF;
        endcase
        merged = (word & ~w_mask) | ((wdata << w_shift) & w_mask);
    end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : CPU-side initiator for a word-addressed data memory. Turns
//               byte/half/word loads and stores into aligned word accesses,
//               using read-modify-write for sub-word stores.
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_BYTES  = 128
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_error,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_write_enable,
    output logic [31:0]           mem_write_data,
    input  logic [31:0]           mem_read_data
);

    localparam logic [ADDR_WIDTH-1:0] c_mem_limit = ADDR_WIDTH'(MEM_BYTES);

    lsu_state_t            r_state;
    lsu_state_t            w_next_state;

    logic                  r_write;
    logic [1:0]            r_size;
    logic                  r_signed;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [31:0]           r_wdata;
    logic [31:0]           r_word;
    logic                  r_error;

    logic                  w_accept;
    logic                  w_req_error;
    logic [ADDR_WIDTH-1:0] w_word_addr;
    logic [31:0]           w_extracted;
    logic [31:0]           w_merged;

    assign w_accept    = req_valid && req_ready;
    assign w_word_addr = {r_addr[ADDR_WIDTH-1:2], 2'b00};

    // Classify the incoming request; only meaningful on the accept edge
    always_comb begin
        w_req_error = 1'b0;
        if (req_size == SIZE_RSVD)                            w_req_error = 1'b1;
        if ((req_size == SIZE_HALF) && req_addr[0])           w_req_error = 1'b1;
        if ((req_size == SIZE_WORD) && (req_addr[1:0] != 2'b00)) w_req_error = 1'b1;
        if (req_addr >= c_mem_limit)                          w_req_error = 1'b1;
    end

    // Lane extraction and merge operate on the captured memory word
    byte_lane_align u_align (
        .word      (r_word),
        .offset    (r_addr[1:0]),
        .size      (r_size),
        .is_signed (r_signed),
        .wdata     (r_wdata),
        .rdata     (w_extracted),
        .merged    (w_merged)
    );

    // State register
    always_ff @(posedge clock) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next_state;
    end

    // Request latch and read-word capture; the CPU may change req_* after accept
    always_ff @(posedge clock) begin
        if (reset) begin
            r_write  <= 1'b0;
            r_size   <= SIZE_BYTE;
            r_signed <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_word   <= '0;
            r_error  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_write  <= req_write;
                r_size   <= req_size;
                r_signed <= req_signed;
                r_addr   <= req_addr;
                r_wdata  <= req_wdata;
                r_error  <= w_req_error;
            end
            if (r_state == READ) r_word <= mem_read_data;
        end
    end

    // Next-state: errors skip memory, word stores skip the read
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_req_error)                              w_next_state = RESP;
                    else if (req_write && (req_size == SIZE_WORD)) w_next_state = WRITE;
                    else                                          w_next_state = READ;
                end
            end
            READ:    w_next_state = r_write ? WRITE : RESP;
            WRITE:   w_next_state = RESP;
            RESP:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Outputs decoded from state; reset forces the handshake and write enable low
    always_comb begin
        req_ready        = 1'b0;
        resp_valid       = 1'b0;
        resp_rdata       = '0;
        resp_error       = 1'b0;
        mem_address      = '0;
        mem_write_enable = 1'b0;
        mem_write_data   = '0;
        case (r_state)
            IDLE: req_ready = !reset;
            READ: mem_address = w_word_addr;
            WRITE: begin
                mem_address      = w_word_addr;
                mem_write_enable = !reset;
                mem_write_data   = w_merged;
            end
            RESP: begin
                resp_valid = !reset;
                resp_error = r_error;
                resp_rdata = (r_error || r_write) ? 32'h0 : w_extracted;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Directed self-checking bench for load_store_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic [31:0] mem_address;
    logic        mem_write_enable;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    logic [31:0] mem [0:31];

    int checks;
    int failures;

    load_store_unit #(.ADDR_WIDTH(32), .MEM_BYTES(128)) dut (
        .clock            (clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_write        (req_write),
        .req_size         (req_size),
        .req_signed       (req_signed),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .resp_valid       (resp_valid),
        .resp_rdata       (resp_rdata),
        .resp_error       (resp_error),
        .mem_address      (mem_address),
        .mem_write_enable (mem_write_enable),
        .mem_write_data   (mem_write_data),
        .mem_read_data    (mem_read_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Bench data memory: combinational read, write on the rising edge
    assign mem_read_data = mem[mem_address[6:2]];
    always @(posedge clk) begin
        if (mem_write_enable) mem[mem_address[6:2]] <= mem_write_data;
    end

    // Issue one request and observe cycles 1..8 after the accept edge
    task automatic do_req(input logic wr, input logic [1:0] sz, input logic sg,
                          input logic [31:0] ad, input logic [31:0] wd,
                          output int rcyc, output logic [31:0] rdat, output logic rerr,
                          output int wcnt, output int wcyc,
                          output logic [31:0] wdat, output logic [31:0] wadr);
        rcyc = 0; rdat = 32'h0; rerr = 1'b0; wcnt = 0; wcyc = 0; wdat = 32'h0; wadr = 32'h0;
        @(negedge clk);
        for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
        req_write = wr; req_size = sz; req_signed = sg; req_addr = ad; req_wdata = wd;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_write = 1'b0; req_size = 2'd3; req_signed = 1'b0;
        req_addr = 32'hFFFF_FFFF; req_wdata = 32'h0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (mem_write_enable) begin
                wcnt++; wcyc = k; wdat = mem_write_data; wadr = mem_address;
            end
            if (resp_valid) begin
                rcyc = k; rdat = resp_rdata; rerr = resp_error;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL reset_ready_in_reset got %b exp 0", req_ready); end
        checks++; if (mem_write_enable !== 1'b0) begin failures++; $display("FAIL reset_we_in_reset got %b exp 0", mem_write_enable); end
        reset = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got %b exp 1", req_ready); end
        checks++; if (resp_valid !== 1'b0 || resp_error !== 1'b0 || resp_rdata !== 32'h0) begin
            failures++; $display("FAIL reset_resp got v=%b e=%b d=%h exp 0/0/0", resp_valid, resp_error, resp_rdata); end
        checks++; if (mem_write_enable !== 1'b0 || mem_address !== 32'h0 || mem_write_data !== 32'h0) begin
            failures++; $display("FAIL reset_mem got we=%b a=%h d=%h exp 0/0/0", mem_write_enable, mem_address, mem_write_data); end
    endtask

    task automatic test_byte_load;
        int rc, wc, wy; logic [31:0] rd, wdt, wa; logic er;
        do_req(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, rc, rd, er, wc, wy, wdt, wa);
        checks++; if (rc !== 2) begin failures++; $display("FAIL lb_latency got %0d exp 2", rc); end
        checks++; if (rd !== 32'hFFFF_FF88) begin failures++; $display("FAIL lb_data got %h exp ffffff88", rd); end
        checks++; if (er !== 1'b0 || wc !== 0) begin failures++; $display("FAIL lb_err_we got e=%b we=%0d exp 0/0", er, wc); end
        do_req(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, rc, rd, er, wc, wy, wdt, wa);
        checks++; if (rd !== 32'h0000_0088 || rc !== 2) begin failures++; $display("FAIL lbu_data got %h@%0d exp 00000088@2", rd, rc); end
    endtask

    task automatic test_byte_store;
        int rc, wc, wy; logic [31:0] rd, wdt, wa; logic er;
        do_req(1'b1, 2'd0, 1'b0, 32'h11, 32'hFFFF_FFCC, rc, rd, er, wc, wy, wdt, wa);
        checks++; if (wc !== 1 || wy !== 2) begin failures++; $display("FAIL sb_we got count=%0d cyc=%0d exp 1/2", wc, wy); end
        checks++; if (wdt !== 32'h8899_CCBB || wa !== 32'h10) begin failures++; $display("FAIL sb_wdata got %h@%h exp 8899ccbb@10", wdt, wa); end
        checks++; if (rc !== 3 || rd !== 32'h0 || er !== 1'b0) begin failures++; $display("FAIL sb_resp got cyc=%0d d=%h e=%b exp 3/0/0", rc, rd, er); end
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rc, rd, er, wc, wy, wdt, wa);
        checks++; if (rd !== 32'h8899_CCBB || rc !== 2) begin failures++; $display("FAIL lw_after_sb got %h@%0d exp 8899ccbb@2", rd, rc); end
    endtask

    task automatic test_word_store_half_load;
        int rc, wc, wy; logic [31:0] rd, wdt, wa; logic er;
        do_req(1'b1, 2'd2, 1'b0, 32'h14, 32'hDEAD_BEEF, rc, rd, er, wc, wy, wdt, wa);
        checks++; if (wc !== 1 || wy !== 1) begin failures++; $display("FAIL sw_we got count=%0d cyc=%0d exp 1/1", wc, wy); end
        checks++; if (wdt !== 32'hDEAD_BEEF || wa !== 32'h14) begin failures++; $display("FAIL sw_wdata got %h@%h exp deadbeef@14", wdt, wa); end
        checks++; if (rc !== 2) begin failures++; $display("FAIL sw_latency got %0d exp 2", rc); end
        do_req(1'b0, 2'd1, 1'b0, 32'h16, 32'h0, rc, rd, er, wc, wy, wdt, wa);
        checks++; if (rd !== 32'h0000_DEAD) begin failures++; $display("FAIL lhu_data got %h exp 0000dead", rd); end
        do_req(1'b0, 2'd1, 1'b1, 32'h14, 32'h0, rc, rd, er, wc, wy, wdt, wa);
        checks++; if (rd !== 32'hFFFF_BEEF) begin failures++; $display("FAIL lh_data got %h exp ffffbeef", rd); end
    endtask

    task automatic test_errors;
        int rc, wc, wy; logic [31:0] rd, wdt, wa; logic er;
        logic [31:0] addrs [4];
        logic [1:0]  sizes [4];
        logic        wrs   [4];
        addrs = '{32'h11, 32'h12, 32'h80, 32'h20};
        sizes = '{2'd1, 2'd2, 2'd2, 2'd3};
        wrs   = '{1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            do_req(wrs[i], sizes[i], 1'b0, addrs[i], 32'h1234_5678, rc, rd, er, wc, wy, wdt, wa);
            checks++; if (rc !== 1 || er !== 1'b1 || rd !== 32'h0 || wc !== 0) begin
                failures++; $display("FAIL error_case%0d got cyc=%0d e=%b d=%h we=%0d exp 1/1/0/0", i, rc, er, rd, wc); end
        end
        checks++; if (mem[5] !== 32'hDEAD_BEEF || mem[8] !== 32'h0) begin
            failures++; $display("FAIL error_mem got %h/%h exp deadbeef/0", mem[5], mem[8]); end
    endtask

    task automatic test_reset_mid_op;
        int bad;
        bad = 0;
        @(negedge clk);
        req_write = 1'b1; req_size = 2'd0; req_signed = 1'b0; req_addr = 32'h10; req_wdata = 32'h55;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (mem_write_enable || resp_valid) bad++;
        end
        reset = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rst_mid_ready got %b exp 1", req_ready); end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (mem_write_enable || resp_valid) bad++;
        end
        checks++; if (bad !== 0) begin failures++; $display("FAIL rst_mid_activity got %0d exp 0", bad); end
        checks++; if (mem[4] !== 32'h8899_CCBB) begin failures++; $display("FAIL rst_mid_mem got %h exp 8899ccbb", mem[4]); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] addrs [3];
        logic [1:0]  sizes [3];
        logic [31:0] expd  [3];
        logic [31:0] got   [3];
        int acc_cyc [3];
        int nacc, nresp;
        logic accepting;
        addrs = '{32'h10, 32'h14, 32'h15};
        sizes = '{2'd2, 2'd2, 2'd0};
        expd  = '{32'h8899_CCBB, 32'hDEAD_BEEF, 32'h0000_00BE};
        nacc = 0; nresp = 0;
        @(negedge clk);
        req_write = 1'b0; req_signed = 1'b0; req_wdata = 32'h0;
        req_addr = addrs[0]; req_size = sizes[0]; req_valid = 1'b1;
        for (int c = 0; c < 40 && nresp < 3; c++) begin
            if (c > 0) @(negedge clk);
            if (resp_valid) begin
                if (nresp < 3) got[nresp] = resp_rdata;
                nresp++;
            end
            accepting = req_valid && req_ready;
            @(posedge clk);
            #1;
            if (accepting) begin
                acc_cyc[nacc] = c;
                nacc++;
                if (nacc < 3) begin
                    req_addr = addrs[nacc]; req_size = sizes[nacc];
                end else begin
                    req_valid = 1'b0;
                end
            end
        end
        req_valid = 1'b0;
        checks++; if (nacc !== 3 || nresp !== 3) begin failures++; $display("FAIL b2b_counts got acc=%0d resp=%0d exp 3/3", nacc, nresp); end
        if (nacc == 3) begin
            checks++; if (acc_cyc[1] - acc_cyc[0] !== 3 || acc_cyc[2] - acc_cyc[1] !== 3) begin
                failures++; $display("FAIL b2b_spacing got %0d/%0d exp 3/3", acc_cyc[1] - acc_cyc[0], acc_cyc[2] - acc_cyc[1]); end
        end
        for (int i = 0; i < 3; i++) begin
            if (i < nresp) begin
                checks++; if (got[i] !== expd[i]) begin failures++; $display("FAIL b2b_data%0d got %h exp %h", i, got[i], expd[i]); end
            end
        end
    endtask

    initial begin
        checks = 0; failures = 0;
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
        req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        for (int i = 0; i < 32; i++) mem[i] = 32'h0;
        mem[4] = 32'h8899_AABB;
        test_reset();
        test_byte_load();
        test_byte_store();
        test_word_store_half_load();
        test_errors();
        test_reset_mid_op();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
